// File: rtl/if_fetch_pkg.sv
// Shared IF-stage definitions: bus widths, stall-bus fields, FSM encodings.
// No logic; pure types and constants.
// Imported by if_fetch and its sub-module.
package if_fetch_pkg;

    localparam int IF_TO_ID_WD = 33;
    localparam int BR_WD       = 33;
    localparam int STALL_WD    = 6;
    localparam int StallBus    = STALL_WD;

    // Stall-bus bit positions and flag meanings
    localparam int   STALL_IF = 0;
    localparam int   STALL_ID = 1;
    localparam logic Stop     = 1'b1;
    localparam logic NoStop   = 1'b0;

    // PC held during reset; the first fetch is RESET_PC + 4
    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFBF_FFFC;

    typedef enum logic [1:0] {
        S_RESET    = 2'd0,
        S_RUN      = 2'd1,
        S_STALL    = 2'd2,
        S_STALL_BR = 2'd3
    } if_state_e;

endpackage

// File: rtl/if_inst_hold.sv
// Captures the SRAM read word while ID is stalled so the instruction is not lost.
// Latency: captured word visible one cycle after the first stalled cycle.
// Backpressure: holds its value while stall persists; valid drops when ID resumes.
module if_inst_hold (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_id_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] hold_o,
    output logic        hold_vld_o
);

    logic [31:0] hold_q, hold_d;
    logic        vld_q,  vld_d;

    // Capture on the first stalled cycle only; later SRAM data is a refetch of nothing useful
    always_comb begin
        hold_d = hold_q;
        vld_d  = vld_q;
        if (stall_id_i) begin
            if (!vld_q) begin
                hold_d = rdata_i;
                vld_d  = 1'b1;
            end
        end else begin
            vld_d = 1'b0;
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= 32'h0;
            vld_q  <= 1'b0;
        end else begin
            hold_q <= hold_d;
            vld_q  <= vld_d;
        end
    end

    assign hold_o     = hold_q;
    assign hold_vld_o = vld_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: owns PC, drives the instruction SRAM, keeps redirects seen while stalled.
// Latency: SRAM data for the presented pc returns one cycle later.
// Backpressure: stall[IF] freezes pc; stall[ID] parks the returning word in the hold buffer.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [STALL_WD-1:0]    stall,
    input  logic [BR_WD-1:0]       br_bus,
    output logic [IF_TO_ID_WD-1:0] if_to_id_bus,
    output logic                   inst_sram_en,
    output logic [3:0]             inst_sram_wen,
    output logic [31:0]            inst_sram_addr,
    output logic [31:0]            inst_sram_wdata,
    input  logic [31:0]            inst_sram_rdata,
    output logic [31:0]            inst_hold,
    output logic                   inst_hold_valid,
    output logic                   adel
);

    if_state_e   state_q, state_d;
    logic [31:0] pc_q,    pc_d;
    logic        ce_q,    ce_d;
    logic [31:0] pend_q,  pend_d;
    logic        adel_q,  adel_d;

    logic        br_e;
    logic [31:0] br_addr;
    logic        stall_if;
    logic        adel_comb;
    logic [31:0] next_pc;
    logic        stall_unused;

    assign br_e         = br_bus[32];
    assign br_addr      = br_bus[31:0];
    assign stall_if     = (stall[STALL_IF] == Stop);
    assign stall_unused = ^stall[STALL_WD-1:2];
    assign adel_comb    = (pc_q[1:0] != 2'b00);

    // Next-PC priority: parked redirect, then live branch, then sequential (wraps at 2^32)
    always_comb begin
        if (state_q == S_STALL_BR) begin
            next_pc = pend_q;
        end else if (br_e) begin
            next_pc = br_addr;
        end else begin
            next_pc = pc_q + 32'd4;
        end
    end

    // Fetch FSM: advance pc when not stalled, park a redirect that arrives during a stall
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ce_d    = ce_q;
        pend_d  = pend_q;
        adel_d  = ce_q & adel_comb;
        case (state_q)
            S_RESET: begin
                // IF stall is not honoured on the very first fetch
                state_d = S_RUN;
                ce_d    = 1'b1;
                pc_d    = next_pc;
            end
            S_RUN: begin
                if (!stall_if) begin
                    pc_d = next_pc;
                end else if (br_e) begin
                    pend_d  = br_addr;
                    state_d = S_STALL_BR;
                end else begin
                    state_d = S_STALL;
                end
            end
            S_STALL: begin
                if (!stall_if) begin
                    pc_d    = next_pc;
                    state_d = S_RUN;
                end else if (br_e) begin
                    pend_d  = br_addr;
                    state_d = S_STALL_BR;
                end
            end
            S_STALL_BR: begin
                // ID keeps re-presenting the same branch; further pulses are ignored
                if (!stall_if) begin
                    pc_d    = next_pc;
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_RESET;
            end
        endcase
    end

    // State registers; reset discards any parked redirect
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RESET;
            pc_q    <= RESET_PC;
            ce_q    <= 1'b0;
            pend_q  <= 32'h0;
            adel_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ce_q    <= ce_d;
            pend_q  <= pend_d;
            adel_q  <= adel_d;
        end
    end

    assign inst_sram_en    = ce_q & ~adel_comb;
    assign inst_sram_wen   = 4'b0000;
    assign inst_sram_addr  = pc_q;
    assign inst_sram_wdata = 32'h0;
    assign if_to_id_bus    = {ce_q & ~adel_comb, pc_q};
    assign adel            = adel_q;

    if_inst_hold u_hold (
        .clk        (clk),
        .rst        (rst),
        .stall_id_i (stall[STALL_ID]),
        .rdata_i    (inst_sram_rdata),
        .hold_o     (inst_hold),
        .hold_vld_o (inst_hold_valid)
    );

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: scoreboard of expected {ce,pc} and hold-buffer values.
// Expected values are pushed when stimulus is applied and popped after the clock edge.
// Outputs sampled 1 time unit after the rising edge.
module tb_if_fetch;

    localparam logic [31:0] RST_PC = 32'hBFBF_FFFC;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        br_e;
    logic [31:0] br_addr;
    logic [32:0] if_to_id_bus;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;
    logic [31:0] inst_hold;
    logic        inst_hold_valid;
    logic        adel;

    int n_checks = 0;
    int n_fail   = 0;

    logic [32:0] exp_bus_q[$];
    logic [32:0] exp_hold_q[$];
    logic [32:0] exp;

    if_fetch #(.RESET_PC(RST_PC)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .br_bus          ({br_e, br_addr}),
        .if_to_id_bus    (if_to_id_bus),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_wen   (inst_sram_wen),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata),
        .inst_hold       (inst_hold),
        .inst_hold_valid (inst_hold_valid),
        .adel            (adel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 6'b0; br_e = 1'b0; br_addr = 32'h0; inst_sram_rdata = 32'h0;
        repeat (3) tick();
        n_checks++;
        if (if_to_id_bus !== {1'b0, RST_PC}) begin
            n_fail++; $display("FAIL reset_bus got=%h exp=%h", if_to_id_bus, {1'b0, RST_PC});
        end
        n_checks++;
        if ({inst_sram_en, adel, inst_hold_valid} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags got en/adel/hv=%b exp=000", {inst_sram_en, adel, inst_hold_valid});
        end
        n_checks++;
        if ({inst_sram_wen, inst_sram_wdata} !== 36'h0) begin
            n_fail++; $display("FAIL reset_wr got wen=%h wdata=%h exp=0", inst_sram_wen, inst_sram_wdata);
        end
        rst = 1'b0;
        exp_bus_q.push_back({1'b1, 32'hBFC0_0000});
        exp_bus_q.push_back({1'b1, 32'hBFC0_0004});
        exp_bus_q.push_back({1'b1, 32'hBFC0_0008});
        for (int i = 0; i < 3; i++) begin
            tick();
            exp = exp_bus_q.pop_front();
            n_checks++;
            if (if_to_id_bus !== exp || inst_sram_en !== 1'b1 || inst_sram_addr !== exp[31:0]) begin
                n_fail++; $display("FAIL reset_seq%0d got bus=%h en=%b exp bus=%h en=1", i, if_to_id_bus, inst_sram_en, exp);
            end
        end
    endtask

    task automatic test_branch();
        tick(); tick();
        n_checks++;
        if (inst_sram_addr !== 32'hBFC0_0010) begin
            n_fail++; $display("FAIL branch_pre got pc=%h exp=bfc00010", inst_sram_addr);
        end
        br_e = 1'b1; br_addr = 32'hBFC0_0100;
        exp_bus_q.push_back({1'b1, 32'hBFC0_0100});
        exp_bus_q.push_back({1'b1, 32'hBFC0_0104});
        tick();
        br_e = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (i == 1) tick();
            exp = exp_bus_q.pop_front();
            n_checks++;
            if (if_to_id_bus !== exp) begin
                n_fail++; $display("FAIL branch%0d got=%h exp=%h", i, if_to_id_bus, exp);
            end
        end
    endtask

    task automatic test_wrap();
        br_e = 1'b1; br_addr = 32'hFFFF_FFFC;
        exp_bus_q.push_back({1'b1, 32'hFFFF_FFFC});
        exp_bus_q.push_back({1'b1, 32'h0000_0000});
        exp_bus_q.push_back({1'b1, 32'h0000_0004});
        for (int i = 0; i < 3; i++) begin
            tick();
            br_e = 1'b0;
            exp = exp_bus_q.pop_front();
            n_checks++;
            if (if_to_id_bus !== exp) begin
                n_fail++; $display("FAIL wrap%0d got=%h exp=%h", i, if_to_id_bus, exp);
            end
        end
    endtask

    task automatic test_stall_branch();
        br_e = 1'b1; br_addr = 32'hBFC0_0020;
        tick();
        br_e = 1'b0;
        n_checks++;
        if (inst_sram_addr !== 32'hBFC0_0020) begin
            n_fail++; $display("FAIL stall_br_pre got pc=%h exp=bfc00020", inst_sram_addr);
        end
        // stall cycles: plain, branch pulse, ignored second pulse; then release
        for (int i = 0; i < 4; i++) begin
            stall   = (i < 3) ? 6'b000011 : 6'b000000;
            br_e    = (i == 1 || i == 2);
            br_addr = (i == 1) ? 32'h8000_0040 : 32'h1234_5678;
            exp_bus_q.push_back((i < 3) ? {1'b1, 32'hBFC0_0020} : {1'b1, 32'h8000_0040});
            tick();
            exp = exp_bus_q.pop_front();
            n_checks++;
            if (if_to_id_bus !== exp) begin
                n_fail++; $display("FAIL stall_br%0d got=%h exp=%h", i, if_to_id_bus, exp);
            end
        end
        br_e = 1'b0;
        exp_bus_q.push_back({1'b1, 32'h8000_0044});
        tick();
        exp = exp_bus_q.pop_front();
        n_checks++;
        if (if_to_id_bus !== exp) begin
            n_fail++; $display("FAIL stall_br_after got=%h exp=%h", if_to_id_bus, exp);
        end
    endtask

    task automatic test_hold();
        n_checks++;
        if (inst_hold_valid !== 1'b0) begin
            n_fail++; $display("FAIL hold_pre got valid=%b exp=0", inst_hold_valid);
        end
        // {valid, data} after each edge: two stalled cycles, then release
        for (int i = 0; i < 3; i++) begin
            stall           = (i < 2) ? 6'b000010 : 6'b000000;
            inst_sram_rdata = (i == 0) ? 32'h3C01_1234 : 32'hDEAD_BEEF;
            exp_hold_q.push_back((i < 2) ? {1'b1, 32'h3C01_1234} : {1'b0, 32'h3C01_1234});
            tick();
            exp = exp_hold_q.pop_front();
            n_checks++;
            if ({inst_hold_valid, inst_hold} !== exp) begin
                n_fail++; $display("FAIL hold%0d got v=%b d=%h exp v=%b d=%h", i, inst_hold_valid, inst_hold, exp[32], exp[31:0]);
            end
        end
    endtask

    task automatic test_misaligned();
        br_e = 1'b1; br_addr = 32'h0000_0006;
        tick();
        br_e = 1'b0;
        n_checks++;
        if (if_to_id_bus !== {1'b0, 32'h0000_0006} || inst_sram_en !== 1'b0 || adel !== 1'b0) begin
            n_fail++; $display("FAIL misalign_c1 got bus=%h en=%b adel=%b exp bus=000000006 en=0 adel=0", if_to_id_bus, inst_sram_en, adel);
        end
        tick();
        n_checks++;
        if (adel !== 1'b1 || inst_sram_en !== 1'b0) begin
            n_fail++; $display("FAIL misalign_c2 got adel=%b en=%b exp adel=1 en=0", adel, inst_sram_en);
        end
        br_e = 1'b1; br_addr = 32'h0000_0100;
        tick();
        br_e = 1'b0;
        tick();
        n_checks++;
        if (adel !== 1'b0 || inst_sram_en !== 1'b1) begin
            n_fail++; $display("FAIL misalign_clear got adel=%b en=%b exp adel=0 en=1", adel, inst_sram_en);
        end
    endtask

    task automatic test_reset_stall_br();
        stall = 6'b000011; br_e = 1'b1; br_addr = 32'h8000_0040;
        tick();
        br_addr = 32'h0000_0044;
        tick();
        br_e = 1'b0;
        rst  = 1'b1;
        tick();
        n_checks++;
        if (if_to_id_bus !== {1'b0, RST_PC} || inst_hold_valid !== 1'b0 || inst_sram_en !== 1'b0) begin
            n_fail++; $display("FAIL rst_stall got bus=%h hv=%b en=%b exp bus=%h hv=0 en=0", if_to_id_bus, inst_hold_valid, inst_sram_en, {1'b0, RST_PC});
        end
        rst = 1'b0;
        // IF stall is still asserted on the first fetch, which must ignore it
        exp_bus_q.push_back({1'b1, 32'hBFC0_0000});
        exp_bus_q.push_back({1'b1, 32'hBFC0_0000});
        exp_bus_q.push_back({1'b1, 32'hBFC0_0004});
        for (int i = 0; i < 3; i++) begin
            stall = (i < 2) ? 6'b000011 : 6'b000000;
            tick();
            exp = exp_bus_q.pop_front();
            n_checks++;
            if (if_to_id_bus !== exp) begin
                n_fail++; $display("FAIL rst_restart%0d got=%h exp=%h", i, if_to_id_bus, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_wrap();
        test_stall_branch();
        test_hold();
        test_misaligned();
        test_reset_stall_br();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
Instruction-fetch stage of the 5-stage MIPS pipeline. It is the producer of the IF→ID bus and the consumer of the ID branch bus.
- Owns the PC register and drives the synchronous instruction SRAM.
- Honours the shared stall bus.
- Keeps a branch redirect that arrives while IF is stalled, so the redirect is not lost.
- Keeps the SRAM read data that arrives while ID is stalled, so the instruction is not lost.

Parameters:
RESET_PC, 32'hBFBF_FFFC, PC value held in reset; first fetched address is RESET_PC+4 = 32'hBFC0_0000
IF_TO_ID_WD, 33, width of if_to_id_bus {ce, pc}
BR_WD, 33, width of br_bus {br_e, br_addr}
STALL_WD, 6, width of stall bus; bit0 = IF, bit1 = ID

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
stall  in  STALL_WD  per-stage stop flags (1 = Stop)
br_bus  in  BR_WD  {br_e, br_addr[31:0]} from ID, combinational, same cycle
if_to_id_bus  out  IF_TO_ID_WD  {ce, pc[31:0]}
inst_sram_en  out  1  SRAM read enable
inst_sram_wen  out  4  always 4'b0000
inst_sram_addr  out  32  fetch address, equals pc
inst_sram_wdata  out  32  always 0
inst_sram_rdata  in  32  SRAM data, valid one cycle after en
inst_hold  out  32  instruction captured while ID was stalled
inst_hold_valid  out  1  ID must use inst_hold instead of inst_sram_rdata
adel  out  1  fetch address misaligned (pc[1:0] != 0) with ce=1

Behaviour:
- Reset values: pc=RESET_PC, ce=0, state=S_RESET, pend_addr=0, inst_hold=0, inst_hold_valid=0, adel=0. Therefore inst_sram_en=0 during reset.
- next_pc priority:
  1. pend_addr, when state is S_STALL_BR
  2. br_addr, when br_e=1
  3. pc+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0)
- Branch delay slot is architectural. The instruction already in flight after a branch is not squashed.
- FSM:
  - S_RESET: on the first cycle with rst=0 → S_RUN, ce<=1, pc<=next_pc. stall[0] is ignored in this state.
  - S_RUN:
    - stall[0]=0: pc<=next_pc.
    - stall[0]=1 and br_e=1: pend_addr<=br_addr, → S_STALL_BR, pc held.
    - stall[0]=1 and br_e=0: → S_STALL, pc held.
  - S_STALL:
    - br_e=1 while still stalled: latch pend_addr, → S_STALL_BR.
    - stall[0]=0: pc<=next_pc (a live br_e is used), → S_RUN.
  - S_STALL_BR: additional br_e pulses are ignored; ID re-presents the same branch. On stall[0]=0: pc<=pend_addr, → S_RUN.
- Combinational outputs:
  - inst_sram_en = ce & ~adel_comb, where adel_comb = (pc[1:0] != 0).
  - inst_sram_addr = pc.
  - if_to_id_bus = {ce & ~adel_comb, pc}.
- adel is registered: adel<=ce & adel_comb each cycle. It remains asserted while pc is held misaligned.
- Hold buffer:
  - Capture: stall[1]=1 and inst_hold_valid=0 → inst_hold<=inst_sram_rdata, inst_hold_valid<=1.
  - Hold: stall[1]=1 and inst_hold_valid=1 → no change.
  - Release: stall[1]=0 → inst_hold_valid<=0. inst_hold keeps its value.
  - ID consumes inst_hold during the release cycle.
- Priority: rst overrides everything. Reset in the middle of a stall or with a pending redirect discards pend_addr and the hold buffer.

Decomposition:
- Shared defines header (existing): IF_TO_ID_WD, BR_WD, StallBus, Stop/NoStop.
- New entries in that header: FSM state encodings S_RESET/S_RUN/S_STALL/S_STALL_BR (2 bits) and RESET_PC default.
- One natural sub-module, if_inst_hold: the 32-bit capture register plus valid flag. Its inputs are stall[1] and rdata.
- PC, next-PC logic and FSM stay in the top module.

Test Plan:
- Reset sequence: rst high 3 cycles, then low. Cycle 1 after release: pc=32'hBFC0_0000, ce=1, inst_sram_en=1. Next cycles: 32'hBFC0_0004, then 32'hBFC0_0008.
- Taken branch: at pc=32'hBFC0_0010 drive br_e=1, br_addr=32'hBFC0_0100 for one cycle, no stall. Next pc=32'hBFC0_0100.
- Branch during stall:
  - stall=6'b000011 for 3 cycles; at pc=32'hBFC0_0020, br_e pulses in stall cycle 2 with br_addr=32'h8000_0040.
  - pc must stay at 32'hBFC0_0020 through the stall. First unstalled cycle: pc=32'h8000_0040. Any br_e seen in S_STALL_BR is ignored.
- Hold buffer:
  - stall[1]=1 for 2 cycles, with rdata=32'h3C01_1234 in cycle 1 and 32'hDEAD_BEEF in cycle 2.
  - inst_hold=32'h3C01_1234 and valid=1 throughout. Valid clears one cycle after stall[1]=0.
- Misaligned redirect: br_e=1, br_addr=32'h0000_0006. Next cycle: inst_sram_en=0, ce bit of bus=0. Following cycle: adel=1.
- Reset in S_STALL_BR: assert rst. Next cycle: pc=RESET_PC, ce=0, inst_hold_valid=0. After release, fetch starts at 32'hBFC0_0000, not at the pending address.
